// File: rtl/lif_integrate.sv
// Leaky integrate stage for one SNN layer: leak, accumulate weighted input spikes,
// hand potentials to lateral inhibition, then apply winner reset / loser inhibition.
module lif_integrate #(
  parameter int N1 = 4,
  parameter int N2 = 3,
  parameter int W = 24,
  parameter int WW = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int INHIB = 16,
  parameter int LI_TIMEOUT = 255,
  localparam int AW = (N1 > 1) ? $clog2(N1) : 1,
  localparam int TW = $clog2(LI_TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_step,
  input  logic [N1-1:0]     spikes_in,
  output logic [AW-1:0]     w_addr,
  output logic              w_rd,
  input  logic [N2*WW-1:0]  w_data,
  output logic [N2*W-1:0]   potentials,
  output logic              start_li,
  input  logic [N2-1:0]     won_lost,
  input  logic              valid_li,
  input  logic              first_spike,
  output logic [N2-1:0]     spike_out,
  output logic              done_step,
  output logic              busy,
  output logic              li_err,
  output logic [2:0]        dbg_state
);

  // Handshake with lateral inhibition: start_li is a one-cycle request issued in FIRE;
  // the first valid_li seen in WAIT_LI is the verdict, valid_li in any other state is ignored.
  typedef enum logic [2:0] {
    S_IDLE, S_LEAK, S_SCAN, S_DRAIN, S_FIRE, S_WAIT, S_UPDATE
  } state_t;

  state_t          state_q, state_d;
  logic [N1-1:0]   spikes_q, spikes_d;
  logic [AW-1:0]   scan_q, scan_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            acc_en_q, acc_en_d;
  logic [N2-1:0]   wl_q, wl_d;
  logic            fs_q, fs_d;
  logic [N2-1:0]   spike_out_q, spike_out_d;
  logic            li_err_q, li_err_d;
  logic [W-1:0]    pot_q [N2];
  logic [W-1:0]    pot_d [N2];
  logic            scan_last;
  logic            timeout;

  function automatic logic [W-1:0] leak(input logic [W-1:0] p);
    if (LEAK_SHIFT == 0) return p;
    return p - (p >> LEAK_SHIFT);
  endfunction

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] p, input logic [WW-1:0] w);
    logic [W:0] s;
    s = {1'b0, p} + (W+1)'(w);
    return s[W] ? {W{1'b1}} : s[W-1:0];
  endfunction

  function automatic logic [W-1:0] inhibit(input logic [W-1:0] p);
    return (p > W'(INHIB)) ? p - W'(INHIB) : '0;
  endfunction

  assign scan_last = (scan_q == AW'(N1 - 1));
  assign timeout   = (state_q == S_WAIT) && !valid_li && (to_cnt_q == TW'(LI_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      spikes_q    <= '0;
      scan_q      <= '0;
      to_cnt_q    <= '0;
      acc_en_q    <= 1'b0;
      wl_q        <= '0;
      fs_q        <= 1'b0;
      spike_out_q <= '0;
      li_err_q    <= 1'b0;
      for (int k = 0; k < N2; k++) pot_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      spikes_q    <= spikes_d;
      scan_q      <= scan_d;
      to_cnt_q    <= to_cnt_d;
      acc_en_q    <= acc_en_d;
      wl_q        <= wl_d;
      fs_q        <= fs_d;
      spike_out_q <= spike_out_d;
      li_err_q    <= li_err_d;
      for (int k = 0; k < N2; k++) pot_q[k] <= pot_d[k];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_step) state_d = S_LEAK;
      S_LEAK:   state_d = S_SCAN;
      S_SCAN:   if (scan_last) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_FIRE;
      S_FIRE:   state_d = S_WAIT;
      S_WAIT: begin
        if (valid_li)     state_d = S_UPDATE;
        else if (timeout) state_d = S_IDLE;
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd      = (state_q == S_SCAN);
    w_addr    = w_rd ? scan_q : '0;
    start_li  = (state_q == S_FIRE);
    done_step = (state_q == S_UPDATE) || timeout;
    busy      = (state_q != S_IDLE);
    spike_out = spike_out_q;
    li_err    = li_err_q;
    dbg_state = state_q;
  end

  // Row j is read in SCAN cycle j and added one cycle later; DRAIN absorbs the last row.
  always_comb begin
    spikes_d    = spikes_q;
    scan_d      = scan_q;
    to_cnt_d    = to_cnt_q;
    acc_en_d    = 1'b0;
    wl_d        = wl_q;
    fs_d        = fs_q;
    spike_out_d = spike_out_q;
    li_err_d    = li_err_q;
    for (int k = 0; k < N2; k++) pot_d[k] = pot_q[k];
    case (state_q)
      S_IDLE: begin
        spikes_d = spikes_in;
        scan_d   = '0;
        to_cnt_d = '0;
      end
      S_LEAK: for (int k = 0; k < N2; k++) pot_d[k] = leak(pot_q[k]);
      S_SCAN: begin
        acc_en_d = spikes_q[scan_q];
        if (!scan_last) scan_d = scan_q + 1'b1;
      end
      S_WAIT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (valid_li) begin
          wl_d = won_lost;
          fs_d = first_spike;
        end else if (timeout) begin
          li_err_d    = 1'b1;
          spike_out_d = '0;
        end
      end
      S_UPDATE: begin
        if (fs_q) begin
          for (int k = 0; k < N2; k++) pot_d[k] = wl_q[k] ? '0 : inhibit(pot_q[k]);
          spike_out_d = wl_q;
        end else begin
          spike_out_d = '0;
        end
      end
      default: ;
    endcase
    if (acc_en_q)
      for (int k = 0; k < N2; k++) pot_d[k] = sat_add(pot_q[k], w_data[k*WW +: WW]);
  end

  for (genvar k = 0; k < N2; k++) begin : g_pot
    assign potentials[k*W +: W] = pot_q[k];
  end

endmodule

// File: tb/tb_lif_integrate.sv
// Bench for lif_integrate: directed literal cases, randomized steps against an
// arithmetic model, and a narrow no-leak instance for saturation and N1 = 1.
module tb_lif_integrate;
  localparam int N1 = 4, N2 = 3, W = 24, WW = 8, LS = 3, INHIB = 16, TO = 255;
  localparam int PW = N2 * W;
  localparam int SW = 10;
  localparam longint MAXP = (longint'(1) << W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic start_step, valid_li, first_spike, w_rd, start_li, done_step, busy, li_err;
  logic [N1-1:0] spikes_in;
  logic [1:0] w_addr;
  logic [N2*WW-1:0] w_data;
  logic [PW-1:0] potentials;
  logic [N2-1:0] won_lost, spike_out;
  logic [2:0] dbg_state;

  logic s_start, s_wrd, s_start_li, s_valid, s_fs, s_done, s_busy, s_err;
  logic [0:0] s_waddr, s_spikes;
  logic [N2*WW-1:0] s_wdata;
  logic [N2*SW-1:0] s_pots;
  logic [N2-1:0] s_wl, s_spk;
  logic [2:0] s_dbg;

  lif_integrate #(.N1(N1), .N2(N2), .W(W), .WW(WW), .LEAK_SHIFT(LS), .INHIB(INHIB),
                  .LI_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start_step(start_step), .spikes_in(spikes_in),
    .w_addr(w_addr), .w_rd(w_rd), .w_data(w_data), .potentials(potentials),
    .start_li(start_li), .won_lost(won_lost), .valid_li(valid_li),
    .first_spike(first_spike), .spike_out(spike_out), .done_step(done_step),
    .busy(busy), .li_err(li_err), .dbg_state(dbg_state));

  lif_integrate #(.N1(1), .N2(N2), .W(SW), .WW(WW), .LEAK_SHIFT(0), .INHIB(INHIB),
                  .LI_TIMEOUT(TO)) u_sat (
    .clk(clk), .rst(rst), .start_step(s_start), .spikes_in(s_spikes),
    .w_addr(s_waddr), .w_rd(s_wrd), .w_data(s_wdata), .potentials(s_pots),
    .start_li(s_start_li), .won_lost(s_wl), .valid_li(s_valid),
    .first_spike(s_fs), .spike_out(s_spk), .done_step(s_done),
    .busy(s_busy), .li_err(s_err), .dbg_state(s_dbg));

  // clock / reset / weight memory
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N2*WW-1:0] wmem [N1];
  always @(posedge clk) if (w_rd) w_data <= wmem[w_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // model and scoreboard
  longint mpot [N2];
  logic [N2-1:0] mspike;
  logic merr;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] hold_val, cmp_e, last_fire, model_fire_val;
  bit holding, chk_en;
  int exp_fire_cyc, exp_done_cyc;
  int n_checks = 0, n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string nm, input bit seen);
    n_checks++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s: event not seen within cycle budget (cycle %0d)", nm, cyc);
    end
  endtask

  function automatic logic [PW-1:0] pack_model();
    logic [PW-1:0] v;
    v = '0;
    for (int k = 0; k < N2; k++) v[k*W +: W] = W'(mpot[k]);
    return v;
  endfunction

  task automatic model_fire(input logic [N1-1:0] sp);
    longint p;
    for (int k = 0; k < N2; k++) begin
      p = mpot[k];
      p = p - (p >> LS);
      for (int j = 0; j < N1; j++)
        if (sp[j]) begin
          p = p + longint'(wmem[j][k*WW +: WW]);
          if (p > MAXP) p = MAXP;
        end
      mpot[k] = p;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (start_li) begin
        if (exp_q.size() == 0) bound_fail("unexpected_start_li", 1'b0);
        else begin
          cmp_e = exp_q.pop_front();
          chk("fire_pots", potentials, cmp_e);
          chk("fire_cycle", cyc, exp_fire_cyc);
          hold_val = cmp_e;
          holding = 1'b1;
        end
      end else if (holding) begin
        chk("hold_pots", potentials, hold_val);
      end
      if (done_step) begin
        chk("done_cycle", cyc, exp_done_cyc);
        holding = 1'b0;
      end
      if (!busy) begin
        chk("idle_pots", potentials, pack_model());
        chk("idle_spike_out", spike_out, mspike);
        chk("idle_li_err", li_err, merr);
      end
    end
  end

  // driver tasks
  task automatic model_clear();
    for (int k = 0; k < N2; k++) mpot[k] = 0;
    mspike = '0;
    merr = 1'b0;
    exp_q.delete();
    holding = 1'b0;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b1;
    start_step = 1'b0;
    valid_li = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    chk_en = 1'b1;
  endtask

  task automatic start(input logic [N1-1:0] sp, input bit poke);
    valid_li = 1'b0;
    spikes_in = sp;
    start_step = 1'b1;
    @(posedge clk); #1;
    start_step = 1'b0;
    exp_fire_cyc = cyc + N1 + 2;
    model_fire(sp);
    model_fire_val = pack_model();
    exp_q.push_back(model_fire_val);
    spikes_in = N1'($urandom);
    if (poke) begin
      @(posedge clk); #1;
      start_step = 1'b1;
      valid_li = 1'b1;
      first_spike = 1'b1;
      won_lost = N2'($urandom);
      @(posedge clk); #1;
      start_step = 1'b0;
      valid_li = 1'b0;
    end
  endtask

  // mode 0: winner, 1: no spike, 2: no verdict (timeout)
  task automatic verdict(input int mode, input int force_k);
    int k;
    int fire_cyc;
    bit seen;
    k = (force_k >= 0) ? force_k : int'($urandom_range(0, N2 - 1));
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (start_li) begin seen = 1'b1; break; end
    end
    bound_fail("start_li_seen", seen);
    if (!seen) return;
    last_fire = potentials;
    fire_cyc = cyc;
    if (mode == 2) begin
      exp_done_cyc = fire_cyc + TO;
    end else begin
      @(posedge clk);
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
      valid_li = 1'b1;
      first_spike = (mode == 0);
      won_lost = '1;
      if (mode == 0) begin
        won_lost = '0;
        won_lost[k] = 1'b1;
      end
      @(posedge clk); #1;
      exp_done_cyc = cyc;
      valid_li = 1'b0;
      won_lost = N2'($urandom);
      first_spike = 1'($urandom);
    end
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_step) begin seen = 1'b1; break; end
    end
    bound_fail("done_step_seen", seen);
    if (mode == 0) begin
      for (int j = 0; j < N2; j++)
        mpot[j] = (j == k) ? 0 : ((mpot[j] > INHIB) ? mpot[j] - INHIB : 0);
      mspike = '0;
      mspike[k] = 1'b1;
    end else begin
      mspike = '0;
      if (mode == 2) merr = 1'b1;
    end
    @(posedge clk); #1;
    chk("busy_fall", busy, 1'b0);
    chk("done_one_cycle", done_step, 1'b0);
  endtask

  int mode, gap;
  bit seen_s;
  int e_s;

  initial begin
    rst = 1'b1; start_step = 1'b0; spikes_in = '0; valid_li = 1'b0; won_lost = '0;
    first_spike = 1'b0; chk_en = 1'b0;
    s_start = 1'b0; s_spikes = 1'b1; s_valid = 1'b0; s_fs = 1'b0; s_wl = '1;
    s_wdata = {8'hFF, 8'h03, 8'hFF};
    for (int j = 0; j < N1; j++) wmem[j] = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_pots", potentials, '0);
    chk("rst_spike_out", spike_out, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_li_err", li_err, 1'b0);
    chk("rst_start_li", start_li, 1'b0);
    chk("rst_done", done_step, 1'b0);
    chk("rst_w_rd", w_rd, 1'b0);
    chk("rst_w_addr", w_addr, '0);
    chk_en = 1'b1;

    // accumulate from zero, then no-spike verdict
    wmem[0] = {8'd10, 8'd20, 8'd30};
    wmem[1] = {8'd1, 8'd2, 8'd3};
    wmem[2] = {8'd5, 8'd5, 8'd5};
    wmem[3] = {8'd9, 8'd9, 8'd9};
    start(4'b0101, 1'b0);
    chk("model_sum", model_fire_val, {24'd15, 24'd25, 24'd35});
    verdict(1, -1);
    chk("dir_sum_fire", last_fire, {24'd15, 24'd25, 24'd35});
    chk("dir_nospike_pots", potentials, {24'd15, 24'd25, 24'd35});
    chk("dir_nospike_out", spike_out, 3'b000);

    // leak 80 -> 70, 7 -> 7
    do_reset();
    wmem[0] = {8'd7, 8'd0, 8'd80};
    start(4'b0001, 1'b0);
    verdict(1, -1);
    start(4'b0000, 1'b0);
    chk("model_leak", model_fire_val, {24'd7, 24'd0, 24'd70});
    verdict(1, -1);
    chk("dir_leak_fire", last_fire, {24'd7, 24'd0, 24'd70});

    // winner n1 with pots {100, 200, 10}
    do_reset();
    wmem[0] = {8'd10, 8'd200, 8'd100};
    start(4'b0001, 1'b1);
    verdict(0, 1);
    chk("dir_win_pots", potentials, {24'd0, 24'd0, 24'd84});
    chk("dir_win_spike", spike_out, 3'b010);

    // reset in the middle of SCAN
    start(4'b1111, 1'b0);
    @(posedge clk); #1;
    chk_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midscan_rst_busy", busy, 1'b0);
    chk("midscan_rst_pots", potentials, '0);
    chk("midscan_rst_state", dbg_state, 3'd0);
    chk("midscan_rst_w_rd", w_rd, 1'b0);
    rst = 1'b0;
    model_clear();
    chk_en = 1'b1;

    // randomized steps against the model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < N1; j++) wmem[j] = (N2*WW)'($urandom);
      mode = (i == 5 || i == 23) ? 2 : int'($urandom_range(0, 1));
      start(N1'($urandom), ($urandom_range(0, 3) == 0));
      verdict(mode, -1);
      if (i == 5) chk("timeout_li_err", li_err, 1'b1);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        valid_li = 1'($urandom);
        first_spike = 1'b1;
        won_lost = N2'($urandom);
        @(posedge clk); #1;
      end
      valid_li = 1'b0;
    end

    // saturation and N1 = 1 on the narrow instance without leak
    for (int s = 1; s <= 6; s++) begin
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      e_s = cyc;
      seen_s = 1'b0;
      for (int i = 0; i < 32; i++) begin
        @(negedge clk);
        if (s_start_li) begin seen_s = 1'b1; break; end
      end
      bound_fail("sat_start_li_seen", seen_s);
      if (s == 1) chk("sat_fire_cycle", cyc, e_s + 3);
      @(posedge clk); #1;
      s_valid = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      seen_s = 1'b0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (s_done) begin seen_s = 1'b1; break; end
      end
      bound_fail("sat_done_seen", seen_s);
      @(posedge clk); #1;
      if (s == 4) chk("sat_below_max", s_pots, {10'd1020, 10'd12, 10'd1020});
      if (s == 6) chk("sat_clamp", s_pots, {10'd1023, 10'd18, 10'd1023});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lif_integrate.md
# lif_integrate

Per-timestep leaky integrate stage for one SNN layer block. Each timestep it leaks every neuron's membrane potential, accumulates synaptic weights for the active input spikes, and presents the potentials to the lateral-inhibition (winner-take-all) stage with a `start_li` pulse. It then waits for that stage's verdict and applies winner reset and loser inhibition before the next timestep.

## Interface
- `N1`, 4: number of input lines (synapses per neuron).
- `N2`, 3: number of neurons; must equal the lateral-inhibition stage's neuron count.
- `W`, 24: membrane potential width (unsigned).
- `WW`, 8: synaptic weight width (unsigned).
- `LEAK_SHIFT`, 3: leak per step is `pot >> LEAK_SHIFT`; 0 disables leak.
- `INHIB`, 16: amount subtracted from each losing neuron when a winner fires.
- `LI_TIMEOUT`, 255: maximum WAIT_LI cycles before abort.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_step` in 1: begin a timestep; sampled only in IDLE.
- `spikes_in` in N1: input spike vector; latched when `start_step` is accepted.
- `w_addr` out clog2(N1): weight-row address.
- `w_rd` out 1: weight-row read strobe.
- `w_data` in N2*WW: row for input j; `[k*WW +: WW]` = weight j→neuron k. Valid the cycle after `w_rd`.
- `potentials` out N2*W: `[k*W +: W]` = neuron k potential (register output).
- `start_li` out 1: one-cycle pulse to the lateral-inhibition stage.
- `won_lost` in N2: verdict vector from the lateral-inhibition stage.
- `valid_li` in 1: verdict valid strobe.
- `first_spike` in 1: 1 = a winner fired (`won_lost` is one-hot); 0 = no spike.
- `spike_out` out N2: one-hot output spike of the last step; all zero if there was no spike.
- `done_step` out 1: one-cycle pulse when the step completes.
- `busy` out 1: high in every state except IDLE.
- `li_err` out 1: sticky flag set on timeout; cleared only by `rst`.

## Operation
- States and transitions:
  - IDLE: go to LEAK on `start_step`.
  - LEAK: 1 cycle.
  - SCAN: N1 cycles.
  - DRAIN: 1 cycle.
  - FIRE: 1 cycle.
  - WAIT_LI: until `valid_li` or timeout.
  - UPDATE: 1 cycle.
  - Then return to IDLE.
- IDLE: latch `spikes_in`; clear the timeout counter.
- LEAK: for each k, `pot[k] <= pot[k] - (pot[k] >> LEAK_SHIFT)`. The result is never negative.
- SCAN: in cycle j (j = 0..N1-1), drive `w_addr = j` and `w_rd = 1`. When row j returns one cycle later and `spikes_in[j] = 1`, do `pot[k] <= sat(pot[k] + w_data[k])`. DRAIN consumes the last row.
- Saturation: the add is performed at W+1 bits and clamps to 2^W-1.
- FIRE: pulse `start_li`. `potentials` are held constant from FIRE until UPDATE.
- WAIT_LI: sample `won_lost` and `first_spike` on the first `valid_li`.
- UPDATE when `first_spike = 1`:
  - The winner (`won_lost` bit) gets pot = 0.
  - Every other neuron gets pot = max(pot - INHIB, 0).
  - `spike_out <= won_lost`.
- UPDATE when `first_spike = 0`: potentials are unchanged and `spike_out <= 0`. `won_lost` (all ones in this case) is ignored.
- UPDATE always pulses `done_step`.
- Timeout: the counter increments each WAIT_LI cycle. When it reaches LI_TIMEOUT without `valid_li`:
  - set `li_err`;
  - `spike_out <= 0`;
  - pulse `done_step`;
  - go to IDLE.
  - Potentials are unchanged.
- Boundary rules:
  - `start_step` outside IDLE is ignored, with no queuing.
  - `valid_li` outside WAIT_LI is ignored.
  - `spikes_in` changes after acceptance have no effect.
  - N1 = 1 is legal.

## Timing
- Reset values:
  - all potentials 0;
  - `spike_out` 0;
  - `start_li`, `done_step`, `w_rd`, `busy`, `li_err` all 0;
  - `w_addr` 0;
  - state IDLE.
- `rst` in any state (including mid-SCAN or WAIT_LI) returns to IDLE on the next edge with reset values.
- Cycle-by-cycle, with `start_step` sampled at edge t:
  - t+1: LEAK.
  - t+2 .. t+1+N1: SCAN.
  - t+2+N1: DRAIN.
  - t+3+N1: FIRE, `start_li` high.
  - From t+4+N1: WAIT_LI.
- If `valid_li` is sampled at edge v: UPDATE at v+1, with `done_step` high in that cycle. `busy` falls at v+2.
- Earliest next accepted `start_step`: the cycle after `done_step`.

## Test plan
- All pots 0, `spikes_in` = 4'b0101, row0 = {n2:10, n1:20, n0:30}, row2 = {5,5,5} → potentials {n0 35, n1 25, n2 15}, `start_li` at t+7.
- Leak: pot 80, no spikes, `LEAK_SHIFT` = 3 → 70 at FIRE. Pot 7 → 7 (7 >> 3 = 0).
- Saturation: pot 0xFFFFF0, weight 0xFF on one active input → 0xFFFFFF with no wrap.
- Winner update: pots {100, 200, 10}, `valid_li` with `won_lost` = 3'b010, `first_spike` = 1 → pots {84, 0, 0}, `spike_out` = 3'b010, `done_step` = 1 for one cycle.
- No spike: `won_lost` = 3'b111, `first_spike` = 0 → pots unchanged, `spike_out` = 0. Separately, hold `valid_li` low for 255 WAIT_LI cycles → `li_err` = 1, `done_step` pulses, return to IDLE.
- `start_step` pulsed mid-SCAN → ignored. `rst` asserted during SCAN → next cycle IDLE, all pots 0, `busy` = 0.
